im_loader: RTL and testbench
============================

# im_loader

Boot-time instruction-memory loader for the monocycle MIPS datapath. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes each word into instruction memory through a word-addressed write port whose address is aligned with the fetch address bits [11:2]. While loading, it holds the CPU stalled and raises `done` when the image is complete.

## Interface
- `BASE_WORD`, default 0: word index (0..1023) at which the first loaded instruction is written.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: begin a load; sampled only in IDLE or DONE.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle. A byte transfers when `in_valid & in_ready` at the rising edge.
- `we` output 1: instruction-memory write strobe, one cycle per word.
- `waddr` output 10: word address for the write (maps to address bits [11:2]).
- `wdata` output 32: assembled instruction word.
- `busy` output 1: load in progress; also drives the CPU hold.
- `done` output 1: load finished; held until the next accepted `start`.
- `err` output 1: load finished abnormally; valid while `done` = 1.

## Operation
- States: IDLE, LEN, DATA, WRITE, CHK (only with the macro), DONE.
- IDLE/DONE, `start` = 1 → LEN. Clears `done`, `err`, the byte counter, the word counter and the checksum. `start` in any other state is ignored.
- LEN:
  - Accepts 2 bytes, big-endian, forming a 16-bit word count `len`.
  - `len` = 0 → DONE with `err` = 0.
  - `len` > 1024 → DONE with `err` = 1; no writes occur.
  - Otherwise → DATA.
- DATA:
  - Accepts bytes into a shift register; the first byte is bits [31:24], the fourth is bits [7:0].
  - After the 4th byte → WRITE.
- WRITE (exactly one cycle, `in_ready` = 0):
  - `we` = 1, `waddr` = (BASE_WORD + word_index) mod 1024, `wdata` = assembled word.
  - Then word_index increments.
  - If word_index reaches `len` → CHK (macro on) or DONE (macro off); else → DATA.
- DONE: `done` = 1 and `busy` = 0; stays until `start`.
- `in_ready` = 1 only in LEN, DATA and CHK.
- `busy` = 1 in LEN, DATA, WRITE and CHK.
- Address arithmetic is 10-bit and wraps from 1023 to 0 without an error.

## Timing
- Reset values: state IDLE; `in_ready`, `we`, `busy`, `done` and `err` all 0; `waddr` and `wdata` 0. All counters and the shift register are 0.
- Reset asserted mid-load aborts immediately. The partial word is discarded, no `we` pulse is issued, and the loader returns to IDLE.
- `start` sampled at edge E: `busy` and `in_ready` are high in the cycle after E.
- 4th byte of a word accepted at edge N: `we` is high during cycle N..N+1, and memory captures the word at edge N+1.
- `in_ready` returns high in the cycle after that edge.
- Peak throughput is 4 bytes per 5 cycles.
- `in_valid` low stalls the loader indefinitely with no timeout. Bytes offered while `in_ready` = 0 are not consumed.
- `done` rises in the cycle after the final write (macro off), or after the checksum byte is accepted (macro on).

## Configuration
- `IM_LOADER_CHECKSUM_EN` defined:
  - The loader keeps an XOR accumulator over all DATA bytes; length bytes are excluded.
  - After the last word it enters CHK and accepts one more byte.
  - If that byte is not equal to the accumulator, `err` = 1.
  - Either way it then goes to DONE.
  - Words already written are not rolled back.
- Not defined: the CHK state and the accumulator are absent, and DONE follows the last WRITE directly.
- The `len` = 0 path never enters CHK in either build.

## Test plan
- Reset, then `start`. Stream 00 02, 24 08 00 05, 24 09 00 0A with `in_valid` held high.
  - Expect `we` pulses with `waddr` = 0 / `wdata` = 0x24080005, then `waddr` = 1 / `wdata` = 0x2409000A.
  - Expect `done` = 1 and `err` = 0.
- `BASE_WORD` = 1022 with a 3-word load: writes occur at `waddr` 1022, 1023, 0; `err` = 0.
- Length bytes 04 01 (1025): `done` = 1, `err` = 1, and no `we` pulse.
- Macro on, 1-word load of 8C 01 00 04:
  - Checksum byte 89 → `err` = 0.
  - Repeat with checksum byte 00 → `err` = 1, and the word is still written.
- Assert `rst_n` = 0 after the 2nd data byte: outputs return to reset values, no `we` pulse occurs, and a new `start` behaves as from IDLE.
- `start` pulsed during DATA and `in_valid` toggled 1/0 every cycle: the load is unaffected, and the written words match the stream.

Source files
------------

// File: rtl/im_loader_if.sv
// im_loader_if: byte-stream input and instruction-memory write bundle
// for the boot loader; slave is the loader side, master the host side.
interface im_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, we, waddr, wdata,
    output busy, done, err
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, we, waddr, wdata,
    input  busy, done, err
  );
endinterface

// File: rtl/im_loader.sv
// im_loader: boot loader assembling big-endian words into instruction memory.
// Define IM_LOADER_CHECKSUM_EN for the trailing XOR checksum byte (CHK state).
module im_loader #(
  parameter int unsigned BASE_WORD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  im_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
`ifdef IM_LOADER_CHECKSUM_EN
    CHK   = 3'd4,
`endif
    DONE  = 3'd5
  } state_t;

  localparam logic [9:0] BASE = 10'(BASE_WORD);

  state_t      state_q;
  logic [15:0] len_q;
  logic [1:0]  bcnt_q;
  logic [10:0] widx_q;
  logic [31:0] sh_q;
  logic        in_ready_q;
  logic        we_q;
  logic [9:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        xfer;
  logic [15:0] len_d;
  logic [31:0] sh_d;
  logic [10:0] widx_d;
  logic [9:0]  waddr_d;

  assign xfer    = bus.in_valid & in_ready_q;
  assign len_d   = {len_q[7:0], bus.in_data};
  assign sh_d    = {sh_q[23:0], bus.in_data};
  assign widx_d  = widx_q + 11'd1;
  // 10-bit add wraps 1023 -> 0 by construction
  assign waddr_d = BASE + widx_q[9:0];

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      bcnt_q     <= '0;
      widx_q     <= '0;
      sh_q       <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q    <= LEN;
            len_q      <= '0;
            bcnt_q     <= '0;
            widx_q     <= '0;
            sh_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        LEN: begin
          if (xfer) begin
            len_q  <= len_d;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q[0]) begin
              bcnt_q <= '0;
              if (len_d == 16'd0) begin
                state_q    <= DONE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                err_q      <= 1'b0;
              end else if (len_d > 16'd1024) begin
                state_q    <= DONE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                err_q      <= 1'b1;
              end else begin
                state_q <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (xfer) begin
            sh_q   <= sh_d;
            bcnt_q <= bcnt_q + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.in_data;
`endif
            if (bcnt_q == 2'd3) begin
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              we_q       <= 1'b1;
              waddr_q    <= waddr_d;
              wdata_q    <= sh_d;
            end
          end
        end
        WRITE: begin
          widx_q <= widx_d;
          // len never exceeds 1024 here, so 11 bits suffice
          if (widx_d == len_q[10:0]) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_q    <= CHK;
            in_ready_q <= 1'b1;
`else
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            state_q    <= DATA;
            in_ready_q <= 1'b1;
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            state_q    <= DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= (bus.in_data != csum_q);
          end
        end
`endif
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: two loaders (base 0 and 1022) on one random stream,
// checked every cycle against a transaction-level model of the image.
module tb_im_loader;
  localparam int B1 = 1022;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  im_loader_if b0();
  im_loader_if b1();

  assign b0.start    = start;
  assign b0.in_data  = in_data;
  assign b0.in_valid = in_valid;
  assign b1.start    = start;
  assign b1.in_data  = in_data;
  assign b1.in_valid = in_valid;

  im_loader #(.BASE_WORD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
  );
  im_loader #(.BASE_WORD(B1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a0;
    logic [9:0]  a1;
    logic [31:0] d;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  wr_t         expq[$];
  byte unsigned img[$];
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  bit          prev_we = 0;
  bit          last_wr = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b0.we) mem0[b0.waddr] <= b0.wdata;
    if (b1.we) mem1[b1.waddr] <= b1.wdata;
  end

  // Per-cycle checker
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", b0.in_ready, 0);
      chk("rst_we", b0.we, 0);
      chk("rst_busy", b0.busy, 0);
      chk("rst_done", b0.done, 0);
      chk("rst_err", b0.err, 0);
      chk("rst_waddr", 32'(b0.waddr), 0);
      chk("rst_wdata", b0.wdata, 0);
      chk("rst_we1", b1.we, 0);
      chk("rst_waddr1", 32'(b1.waddr), 0);
      prev_we = 0;
      last_wr = 0;
    end else begin
      if (prev_we) begin
        if (last_wr) begin
`ifdef IM_LOADER_CHECKSUM_EN
          chk("chk_ready", b0.in_ready, 1);
          chk("chk_busy", b0.busy, 1);
          chk("chk_done", b0.done, 0);
`else
          chk("final_done", b0.done, 1);
          chk("final_busy", b0.busy, 0);
          chk("final_ready", b0.in_ready, 0);
`endif
        end else begin
          chk("post_wr_ready", b0.in_ready, 1);
          chk("post_wr_busy", b0.busy, 1);
        end
      end
      last_wr = 0;
      if (b0.we) begin
        chk("we1", b1.we, 1);
        chk("wr_ready_low", b0.in_ready, 0);
        chk("wr_busy", b0.busy, 1);
        if (expq.size() == 0) begin
          chk("we_unexpected", b0.we, 0);
        end else begin
          wr_t e;
          e = expq.pop_front();
          chk("waddr0", 32'(b0.waddr), 32'(e.a0));
          chk("wdata0", b0.wdata, e.d);
          chk("waddr1", 32'(b1.waddr), 32'(e.a1));
          chk("wdata1", b1.wdata, e.d);
          last_wr = (expq.size() == 0);
        end
      end else begin
        chk("we1_idle", b1.we, 0);
      end
      chk("done_busy_excl", 32'(b0.done & b0.busy), 0);
      prev_we = b0.we;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // noise: 0 = valid held high, 1 = one idle cycle per byte, 2 = random gaps
  task automatic send(input logic [7:0] b, input int noise);
    int n;
    int gaps;
    n = 0;
    gaps = (noise == 1) ? 1 : (noise == 2) ? $urandom_range(0, 2) : 0;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      start    = 1'($urandom_range(0, 1));
      tick();
      start    = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!b0.in_ready) begin
      tick();
      n++;
      if (n > 20) begin
        chk("ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  function automatic logic [31:0] word_of(input int i);
    return {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
  endfunction

  // chk_byte < 0 sends the correct checksum
  task automatic do_load(input int len, input int noise, input int chk_byte);
    logic [15:0] l16;
    logic [7:0]  cs;
    logic [7:0]  cb;
    bit          exp_err;
    int          nw;
    int          c0;
    int          exp_lat;
    int          k;
    l16     = 16'(len);
    cs      = 8'h00;
    nw      = (len >= 1 && len <= 1024) ? len : 0;
    exp_err = (len > 1024);
    exp_lat = 2 + 5 * nw;
    for (int i = 0; i < nw; i++) begin
      wr_t e;
      e.a0 = 10'((0 + i) % 1024);
      e.a1 = 10'((B1 + i) % 1024);
      e.d  = word_of(i);
      expq.push_back(e);
      cs = cs ^ e.d[31:24] ^ e.d[23:16] ^ e.d[15:8] ^ e.d[7:0];
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
    chk("start_busy", b0.busy, 1);
    chk("start_ready", b0.in_ready, 1);
    chk("start_done_clr", b0.done, 0);
    chk("start_err_clr", b0.err, 0);
    send(l16[15:8], noise);
    send(l16[7:0], noise);
    for (int i = 0; i < 4 * nw; i++) send(img[i], noise);
`ifdef IM_LOADER_CHECKSUM_EN
    if (nw > 0) begin
      cb = (chk_byte < 0) ? cs : 8'(chk_byte);
      exp_err = (cb != cs);
      send(cb, noise);
      exp_lat = exp_lat + 1;
    end
`else
    cb = 8'(chk_byte);
`endif
    k = 0;
    while (!b0.done && k < 20) begin
      tick();
      k++;
    end
    if (!b0.done) chk("done_timeout", 0, 1);
    if (noise == 0) chk("latency", 32'(cyc - c0), 32'(exp_lat));
    chk("done", b0.done, 1);
    chk("err", b0.err, 32'(exp_err));
    chk("err1", b1.err, 32'(exp_err));
    chk("done_busy", b0.busy, 0);
    chk("done_ready", b0.in_ready, 0);
    chk("writes_left", 32'(expq.size()), 0);
    for (int i = 0; i < 3; i++) tick();
    chk("done_held", b0.done, 1);
    expq.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", b0.busy, 0);
    chk("idle_done", b0.done, 0);
    chk("idle_ready", b0.in_ready, 0);

    // two-word load from the bring-up image
    img = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h24, 8'h09, 8'h00, 8'h0A};
    do_load(2, 0, -1);
    chk("lit_mem0_0", mem0[0], 32'h24080005);
    chk("lit_mem0_1", mem0[1], 32'h2409000A);
    chk("lit_mem1_1022", mem1[1022], 32'h24080005);
    chk("lit_mem1_1023", mem1[1023], 32'h2409000A);
    chk("lit_err", b0.err, 0);

    // three words: base 1022 wraps to 0
    img.delete();
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
    do_load(3, 0, -1);
    chk("wrap_mem1_0", mem1[0], word_of(2));

    img.delete();
    do_load(1025, 0, -1);
    chk("lit_len1025_err", b0.err, 1);
    do_load(0, 0, -1);
    chk("lit_len0_err", b0.err, 0);

`ifdef IM_LOADER_CHECKSUM_EN
    img = '{8'h8C, 8'h01, 8'h00, 8'h04};
    do_load(1, 0, 8'h89);
    chk("lit_csum_ok", b0.err, 0);
    mem0[0] = 32'h0;
    do_load(1, 0, 8'h00);
    chk("lit_csum_bad", b0.err, 1);
    chk("lit_csum_word", mem0[0], 32'h8C010004);
`endif

    // reset after the second data byte aborts the load
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    rst_n = 1'b0;
    expq.delete();
    #1;
    chk("abort_busy", b0.busy, 0);
    chk("abort_ready", b0.in_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    do_load(2, 0, -1);

    // in_valid alternating with ignored start pulses
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
    do_load(4, 1, -1);

    for (int t = 0; t < 12; t++) begin
      int len;
      int r;
      r = $urandom_range(0, 9);
      len = (r == 0) ? 0 : (r == 1) ? 1025 + $urandom_range(0, 3000)
                         : $urandom_range(1, 8);
      img.delete();
      for (int i = 0; i < 4 * len && len <= 1024; i++)
        img.push_back(8'($urandom));
      do_load(len, $urandom_range(0, 2), -1);
    end

    // largest legal image
    img.delete();
    for (int i = 0; i < 4096; i++) img.push_back(8'($urandom));
    do_load(1024, 0, -1);
    chk("full_mem0_1023", mem0[1023], word_of(1023));
    chk("full_mem1_1021", mem1[1021], word_of(1023));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
